// File: rtl/param_array_lookup_pkg.sv
// Shared types and width helpers for the capture-and-query sample store.
// Imported by the storage top and the membership scanner.
package param_array_lookup_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lookup_state_e;

  // Wide enough to hold the value DEPTH itself (fill level, hit count).
  function automatic int hw_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_array_lookup_if.sv
// Lookup handshake bundle: request/key in, busy/done pulse and results out.
interface param_array_lookup_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = param_array_lookup_pkg::hw_width(DEPTH);

  logic              lookup_req;
  logic [DATA_W-1:0] lookup_key;
  logic              lookup_busy;
  logic              lookup_done;
  logic              lookup_hit;
  logic [AW-1:0]     lookup_idx;
  logic [HW-1:0]     lookup_hits;

  modport master (
    output lookup_req, lookup_key,
    input  lookup_busy, lookup_done, lookup_hit, lookup_idx, lookup_hits
  );

  modport slave (
    input  lookup_req, lookup_key,
    output lookup_busy, lookup_done, lookup_hit, lookup_idx, lookup_hits
  );

endinterface

// File: rtl/param_array_scanner.sv
// Sequential membership search: walks every entry once, counting matches and
// remembering the lowest matching index; the parent supplies entry/valid.
module param_array_scanner
  import param_array_lookup_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  param_array_lookup_if.slave        lk,
  output logic [$clog2(DEPTH)-1:0]   scan_idx,
  input  logic [DATA_W-1:0]          entry,
  input  logic                       entry_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = hw_width(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  lookup_state_e     state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [AW-1:0]     scan_idx_q, scan_idx_d;
  logic              acc_hit_q, acc_hit_d;
  logic [AW-1:0]     acc_idx_q, acc_idx_d;
  logic [HW-1:0]     acc_hits_q, acc_hits_d;
  logic              res_hit_q, res_hit_d;
  logic [AW-1:0]     res_idx_q, res_idx_d;
  logic [HW-1:0]     res_hits_q, res_hits_d;
  logic              match;
  logic              busy, done;

  // Entry arrives from registered storage, so a same-cycle write is not seen.
  assign match    = entry_vld && (entry == key_q);
  assign scan_idx = scan_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (lk.lookup_req) state_d = SCAN;
        SCAN:    if (scan_idx_q == LAST_IDX) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  always_comb begin
    key_d      = key_q;
    scan_idx_d = scan_idx_q;
    acc_hit_d  = acc_hit_q;
    acc_idx_d  = acc_idx_q;
    acc_hits_d = acc_hits_q;
    res_hit_d  = res_hit_q;
    res_idx_d  = res_idx_q;
    res_hits_d = res_hits_q;
    if (clear) begin
      scan_idx_d = '0;
      acc_hit_d  = 1'b0;
      acc_idx_d  = '0;
      acc_hits_d = '0;
      res_hit_d  = 1'b0;
      res_idx_d  = '0;
      res_hits_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lk.lookup_req) begin
            key_d      = lk.lookup_key;
            scan_idx_d = '0;
            acc_hit_d  = 1'b0;
            acc_idx_d  = '0;
            acc_hits_d = '0;
            res_hit_d  = 1'b0;
            res_idx_d  = '0;
            res_hits_d = '0;
          end
        end
        SCAN: begin
          if (match) begin
            acc_hit_d  = 1'b1;
            acc_hits_d = acc_hits_q + HW'(1);
            if (!acc_hit_q) acc_idx_d = scan_idx_q;
          end
          scan_idx_d = scan_idx_q + AW'(1);
          // Publish on the last compare so results are already valid in DONE.
          if (scan_idx_q == LAST_IDX) begin
            res_hit_d  = acc_hit_d;
            res_idx_d  = acc_idx_d;
            res_hits_d = acc_hits_d;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx_q <= '0;
      acc_hit_q  <= 1'b0;
      acc_idx_q  <= '0;
      acc_hits_q <= '0;
      res_hit_q  <= 1'b0;
      res_idx_q  <= '0;
      res_hits_q <= '0;
    end else begin
      scan_idx_q <= scan_idx_d;
      acc_hit_q  <= acc_hit_d;
      acc_idx_q  <= acc_idx_d;
      acc_hits_q <= acc_hits_d;
      res_hit_q  <= res_hit_d;
      res_idx_q  <= res_idx_d;
      res_hits_q <= res_hits_d;
    end
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  assign lk.lookup_busy = busy;
  assign lk.lookup_done = done;
  assign lk.lookup_hit  = res_hit_q;
  assign lk.lookup_idx  = res_idx_q;
  assign lk.lookup_hits = res_hits_q;

endmodule

// File: rtl/param_array_lookup.sv
// Circular capture buffer with per-entry valids, async read port, saturating
// counters, and a sequential key-membership lookup via param_array_scanner.
module param_array_lookup
  import param_array_lookup_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(DEPTH)-1:0]      wr_ptr,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic [hw_width(DEPTH)-1:0]    fill_level,
  output logic [CNT_W-1:0]              sample_count,
  param_array_lookup_if.slave           lk
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = hw_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [HW-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_fire;
  logic [AW-1:0]     scan_idx;

  assign wr_fire = wr_en && !clear;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    if (clear) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      cnt_d    = '0;
    end else if (wr_en) begin
      valid_d[wr_ptr_q] = 1'b1;
      // DEPTH is a power of two, so the pointer wraps by natural overflow.
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != HW'(DEPTH)) fill_d = fill_q + HW'(1);
      if (cnt_q != '1)          cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; stale contents are hidden behind the valid bits.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
  assign wr_ptr       = wr_ptr_q;
  assign fill_level   = fill_q;
  assign sample_count = cnt_q;

  param_array_scanner #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .lk        (lk),
    .scan_idx  (scan_idx),
    .entry     (mem_q[scan_idx]),
    .entry_vld (valid_q[scan_idx])
  );

endmodule

// File: tb/tb_param_array_lookup.sv
// Scoreboard bench for param_array_lookup: expected lookup results are queued
// when a request is driven and compared when lookup_done pulses.
module tb_param_array_lookup;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;
  localparam int LAT    = DEPTH + 1;

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    logic [4:0] hits;
    int         cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = '0;
  logic [3:0]       wr_ptr;
  logic [3:0]       rd_addr = '0;
  logic [7:0]       rd_data;
  logic [4:0]       fill_level;
  logic [7:0]       sample_count;

  param_array_lookup_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) lk ();

  param_array_lookup #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ptr       (wr_ptr),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .fill_level   (fill_level),
    .sample_count (sample_count),
    .lk           (lk)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  logic [7:0] mem_m [16];
  bit         vld_m [16];
  int         ptr_m, fill_m, cnt_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (lk.lookup_done === 1'b1) begin
      done_cnt++;
      check_eq("done_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("lookup_hit",  32'(lk.lookup_hit),  32'(e.hit));
        check_eq("lookup_idx",  32'(lk.lookup_idx),  32'(e.idx));
        check_eq("lookup_hits", 32'(lk.lookup_hits), 32'(e.hits));
        check_eq("lookup_latency", 32'(cyc - e.cyc), LAT);
        check_eq("busy_at_done", 32'(lk.lookup_busy), 0);
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      vld_m[i] = 1'b0;
      mem_m[i] = '0;
    end
    ptr_m = 0; fill_m = 0; cnt_m = 0;
  endfunction

  function automatic exp_t model_lookup(input logic [7:0] key);
    exp_t e;
    e.hit = 1'b0; e.idx = '0; e.hits = '0; e.cyc = 0;
    for (int i = 0; i < 16; i++) begin
      if (vld_m[i] && mem_m[i] == key) begin
        if (!e.hit) e.idx = 4'(i);
        e.hit  = 1'b1;
        e.hits = e.hits + 5'd1;
      end
    end
    return e;
  endfunction

  function automatic exp_t mk_exp(input logic h, input int i, input int n);
    exp_t e;
    e.hit = h; e.idx = 4'(i); e.hits = 5'(n); e.cyc = 0;
    return e;
  endfunction

  task automatic do_write(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk);
    mem_m[ptr_m] = d; vld_m[ptr_m] = 1'b1;
    ptr_m = (ptr_m + 1) % 16;
    if (fill_m < 16) fill_m++;
    if (cnt_m < 255) cnt_m++;
    #1; wr_en = 1'b0;
  endtask

  task automatic start_lookup(input logic [7:0] key, input bit push, input exp_t e);
    lk.lookup_req = 1'b1; lk.lookup_key = key;
    if (push) begin
      e.cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    lk.lookup_req = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    check_eq("results_drained", 32'(sb_q.size()), 0);
    sb_q.delete();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_wr_ptr"}, 32'(wr_ptr), 32'(ptr_m));
    check_eq({tag, "_fill"},   32'(fill_level), 32'(fill_m));
    check_eq({tag, "_count"},  32'(sample_count), 32'(cnt_m));
  endtask

  task automatic check_lookup_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(lk.lookup_busy), 0);
    check_eq({tag, "_done"}, 32'(lk.lookup_done), 0);
    check_eq({tag, "_hit"},  32'(lk.lookup_hit), 0);
    check_eq({tag, "_idx"},  32'(lk.lookup_idx), 0);
    check_eq({tag, "_hits"}, 32'(lk.lookup_hits), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    lk.lookup_req = 1'b0;
    lk.lookup_key = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    check_lookup_zero("reset");
    rst_n = 1'b1;

    // Write/read: 8 samples of 7*i.
    for (int i = 0; i < 8; i++) do_write(8'(7 * i));
    check_eq("t1_wr_ptr", 32'(wr_ptr), 8);
    check_eq("t1_fill", 32'(fill_level), 8);
    check_eq("t1_count", 32'(sample_count), 8);
    rd_addr = 4'd3;  #1; check_eq("t1_rd3", 32'(rd_data), 21);
    rd_addr = 4'd10; #1; check_eq("t1_rd10", 32'(rd_data), 0);

    // Static lookups, including key 0 which must ignore invalid entries.
    start_lookup(8'd21, 1'b1, model_lookup(8'd21)); wait_drain();
    start_lookup(8'd99, 1'b1, model_lookup(8'd99)); wait_drain();
    start_lookup(8'd0,  1'b1, mk_exp(1'b1, 0, 1));  wait_drain();

    // Wrap and saturation.
    do_reset();
    for (int i = 0; i < 20; i++) do_write(8'h2A);
    check_eq("t3_wr_ptr", 32'(wr_ptr), 4);
    check_eq("t3_fill", 32'(fill_level), 16);
    check_eq("t3_count", 32'(sample_count), 20);
    start_lookup(8'h2A, 1'b1, mk_exp(1'b1, 0, 16)); wait_drain();
    for (int i = 0; i < 300; i++) do_write(8'($urandom_range(0, 255)));
    check_eq("t3_count_sat", 32'(sample_count), 255);
    check_state("t3_after");

    // Write ahead of the scan pointer is seen.
    do_reset();
    for (int i = 0; i < 12; i++) do_write(8'(100 + i));
    start_lookup(8'd5, 1'b1, mk_exp(1'b1, 12, 1));
    do_write(8'd5);
    wait_drain();

    // Write behind the scan pointer is missed; a request while busy is dropped.
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0; model_reset();
    do_write(8'd100);
    do_write(8'd101);
    saved = done_cnt;
    start_lookup(8'd5, 1'b1, mk_exp(1'b0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    lk.lookup_req = 1'b1; lk.lookup_key = 8'd101;
    @(posedge clk); #1; lk.lookup_req = 1'b0;
    do_write(8'd5);
    wait_drain();
    repeat (20) @(posedge clk);
    #1;
    check_eq("t4_single_done", 32'(done_cnt - saved), 1);
    start_lookup(8'd5, 1'b1, model_lookup(8'd5)); wait_drain();

    // Clear mid-scan with a colliding write.
    for (int i = 0; i < 5; i++) do_write(8'(40 + i));
    saved = done_cnt;
    start_lookup(8'd41, 1'b0, mk_exp(1'b0, 0, 0));
    repeat (4) @(posedge clk);
    #1;
    check_eq("t5_busy_before", 32'(lk.lookup_busy), 1);
    clear = 1'b1; wr_en = 1'b1; wr_data = 8'd7;
    @(posedge clk); #1;
    clear = 1'b0; wr_en = 1'b0; model_reset();
    check_state("t5_clear");
    check_lookup_zero("t5_clear");
    rd_addr = 4'd0; #1; check_eq("t5_rd0", 32'(rd_data), 0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("t5_no_done", 32'(done_cnt - saved), 0);

    // Asynchronous reset between edges mid-scan, then a clean lookup.
    for (int i = 0; i < 3; i++) do_write(8'(60 + i));
    start_lookup(8'd61, 1'b0, mk_exp(1'b0, 0, 0));
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #2;
    model_reset();
    check_state("t6_async");
    check_lookup_zero("t6_async");
    rd_addr = 4'd1; #1; check_eq("t6_rd1", 32'(rd_data), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    do_write(8'd9);
    do_write(8'd9);
    do_write(8'd4);
    start_lookup(8'd9, 1'b1, model_lookup(8'd9)); wait_drain();
    start_lookup(8'd4, 1'b1, mk_exp(1'b1, 2, 1)); wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_array_lookup.md
Name: param_array_lookup

Overview:
- Parametrised successor to the fixed 8x16 register-array sample buffer: a circular write buffer with an asynchronous read port and a saturating sample counter.
- Adds per-entry valid tracking so unwritten entries never match.
- Adds a sequential, handshaked membership search (an RTL "inside" lookup) that reports first-hit index and hit count.
- Sits beside the debug/observation logic as a capture-and-query store.

Parameters:
DATA_W, 8, width of each entry and of the lookup key
DEPTH, 16, number of entries; power of two, >=2
CNT_W, 8, width of sample_count
(derived) AW = $clog2(DEPTH); HW = $clog2(DEPTH+1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of pointer, valids, fill, counter; aborts lookup
wr_en  input  1  write wr_data at wr_ptr this cycle
wr_data  input  DATA_W  write data
wr_ptr  output  AW  next write index
rd_addr  input  AW  read address
rd_data  output  DATA_W  combinational read of mem[rd_addr]; 0 if entry invalid
fill_level  output  HW  number of valid entries, saturates at DEPTH
sample_count  output  CNT_W  accepted writes, saturates at all-ones
lookup_req  input  1  start search; accepted only when lookup_busy=0
lookup_key  input  DATA_W  search key, captured on acceptance
lookup_busy  output  1  high from the cycle after acceptance until lookup_done
lookup_done  output  1  one-cycle pulse when results are valid
lookup_hit  output  1  at least one valid entry equals the key
lookup_idx  output  AW  lowest matching index; 0 if no hit
lookup_hits  output  HW  number of matching valid entries

Behaviour:
- Reset (rst_n=0, async): wr_ptr=0, all valids=0, fill_level=0, sample_count=0, FSM=IDLE, all lookup_* outputs=0. Memory contents are not reset; they are masked by valids.
- Write: when wr_en=1 and clear=0:
  - mem[wr_ptr] <= wr_data; valid[wr_ptr] <= 1.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0, overwriting the oldest entry).
  - fill_level increments until DEPTH, then holds.
  - sample_count increments until 2^CNT_W-1, then holds.
- clear=1: wr_ptr, valids, fill_level and sample_count go to 0 next cycle. A simultaneous wr_en is ignored. An active lookup returns to IDLE with no done pulse, and lookup results clear to 0. clear has priority over everything except rst_n.
- Lookup FSM, states IDLE, SCAN, DONE:
  - IDLE: lookup_req=1 -> capture key, scan_idx=0, clear accumulators, go to SCAN. lookup_busy rises next cycle.
  - SCAN: each cycle compare entry scan_idx (valid && mem==key).
    - On a match, increment the hit count; record the index only if it is the first hit.
    - scan_idx==DEPTH-1 -> DONE.
    - SCAN lasts exactly DEPTH cycles.
  - DONE: lookup_done=1 for one cycle, results registered, busy drops; -> IDLE.
  - Latency from accepted req to done = DEPTH+1 cycles.
- lookup_req while busy is ignored (not queued).
- lookup_hit/idx/hits hold their values until the next accepted req, which zeroes them.
- Write during SCAN is permitted:
  - Entries are compared live, with no snapshot.
  - A write to the entry being compared in the same cycle is compared with the pre-write value.
  - Already-scanned entries are not revisited.
- Widths: fill_level and lookup_hits are HW bits so that DEPTH is representable. Equality compare is full DATA_W unsigned.

Decomposition:
- Package param_array_lookup_pkg: lookup state enum (IDLE, SCAN, DONE) and a function for the HW width calculation.
- One sub-module, param_array_scanner: the FSM, key register and accumulators. It takes the per-index entry/valid from the parent via a scan_idx output and entry/valid inputs.
- The top module keeps the storage, valids, pointer and counters.

Test Plan:
1. Reset, then write 0,7,14,...,49 (8 writes) with DEPTH=16 -> wr_ptr=8, fill=8, sample_count=8, rd_data@3=21, rd_data@10=0.
2. Key 21 after (1) -> done exactly 17 cycles after req; hit=1, idx=3, hits=1. Key 99 -> hit=0, idx=0, hits=0. Key 0 -> hit=1, idx=0, hits=1 (invalid entries 8..15 never match even though 0 is stored nowhere else).
3. 20 writes of 0x2A from reset -> wr_ptr=4, fill=16, sample_count=20; lookup 0x2A -> hits=16, idx=0. Then 300 writes with CNT_W=8 -> sample_count=255.
4. During SCAN of key 5, write 5 to index 12 before scan reaches 12 -> hit, idx=12. Write 5 to index 2 after it was scanned, with no other 5 present -> hit=0. lookup_req pulsed while busy -> no second done.
5. Assert clear mid-SCAN with wr_en=1 -> no done pulse, busy=0, fill=0, wr_ptr=0, sample_count=0 next cycle.
6. Drop rst_n asynchronously mid-SCAN (between edges) -> all outputs 0 immediately. After release a new lookup completes normally.
